// File: rtl/alu_seq_decoder_pkg.sv
// Shared types and constants for the ALU sequencer W-stream decoder.
package alu_seq_pkg;

  localparam int W_WIDTH   = 6;
  localparam int MAX_STEPS = 8;
  localparam int STEP_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BASE   = 3'd1,
    ST_DECODE = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // Op encoding shared with the sequencer controller.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  // Highest-priority matching op: add > sub > mul > div. Caller handles m==0.
  function automatic op_t op_prio(input logic [3:0] m);
    op_t r;
    if (m[OP_ADD])      r = OP_ADD;
    else if (m[OP_SUB]) r = OP_SUB;
    else if (m[OP_MUL]) r = OP_MUL;
    else                r = OP_DIV;
    return r;
  endfunction

  // More than one bit set in the match vector.
  function automatic logic multi_hot(input logic [3:0] m);
    return (m & (m - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/alu_seq_decoder_if.sv
// Observer bus: W sample stream in, decoded op reports out.
interface alu_seq_decoder_if #(
  parameter int W_WIDTH = alu_seq_pkg::W_WIDTH,
  parameter int STEP_W  = alu_seq_pkg::STEP_W
);
  logic               start;
  logic               in_valid;
  logic [W_WIDTH-1:0] in_w;
  logic               op_valid;
  logic [1:0]         op;
  logic [STEP_W-1:0]  op_step;
  logic               ambig;
  logic               mismatch;
  logic               done;
  logic               busy;

  // Side that feeds samples and consumes reports.
  modport master (
    output start, in_valid, in_w,
    input  op_valid, op, op_step, ambig, mismatch, done, busy
  );

  // Decoder side.
  modport slave (
    input  start, in_valid, in_w,
    output op_valid, op, op_step, ambig, mismatch, done, busy
  );
endinterface

// File: rtl/alu_seq_decoder_matcher.sv
// Combinational check of which ops could turn prev into cur with operand b.
// Bit index of match_o equals the op_t code.
module alu_op_matcher #(
  parameter int W_WIDTH = alu_seq_pkg::W_WIDTH,
  parameter int STEP_W  = alu_seq_pkg::STEP_W
) (
  input  logic [W_WIDTH-1:0] prev_i,
  input  logic [STEP_W-1:0]  b_i,
  input  logic [W_WIDTH-1:0] cur_i,
  output logic [3:0]         match_o
);
  import alu_seq_pkg::*;

  logic [W_WIDTH-1:0] bw;
  logic [W_WIDTH-1:0] sum, diff, prod, quot;

  // All arithmetic is modulo 2^W_WIDTH; divide is guarded against b==0.
  always_comb begin
    bw      = W_WIDTH'(b_i);
    sum     = prev_i + bw;
    diff    = prev_i - bw;
    prod    = prev_i * bw;
    quot    = (bw != '0) ? (prev_i / bw) : '0;
    match_o = '0;
    match_o[OP_ADD] = (sum  == cur_i);
    match_o[OP_SUB] = (diff == cur_i);
    match_o[OP_MUL] = (prod == cur_i);
    match_o[OP_DIV] = (bw != '0) && (quot == cur_i);
  end

endmodule

// File: rtl/alu_seq_decoder.sv
// Protocol checker beside the ALU sequencer: recovers the op applied at
// each step of the W register stream, mirroring the producer's B counter.
module alu_seq_decoder #(
  parameter int W_WIDTH   = alu_seq_pkg::W_WIDTH,
  parameter int MAX_STEPS = alu_seq_pkg::MAX_STEPS,
  parameter int STEP_W    = alu_seq_pkg::STEP_W
) (
  input  logic               clk,
  input  logic               reset,
  alu_seq_decoder_if.slave   bus
);
  import alu_seq_pkg::*;

  state_t             state_q, state_d;
  logic [W_WIDTH-1:0] prev_q, prev_d;
  logic [STEP_W-1:0]  b_q, b_d;
  logic               op_valid_q, op_valid_d;
  op_t                op_q, op_d;
  logic [STEP_W-1:0]  op_step_q, op_step_d;
  logic               ambig_q, ambig_d;
  logic               mismatch_q, mismatch_d;
  logic               done_q, done_d;
  logic [3:0]         match;

  alu_op_matcher #(.W_WIDTH(W_WIDTH), .STEP_W(STEP_W)) u_match (
    .prev_i  (prev_q),
    .b_i     (b_q),
    .cur_i   (bus.in_w),
    .match_o (match)
  );

  // Next-state and registered-output logic; start overrides every state.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    b_d        = b_q;
    op_valid_d = 1'b0;
    op_d       = op_q;
    op_step_d  = op_step_q;
    ambig_d    = ambig_q;
    mismatch_d = mismatch_q;
    done_d     = done_q;
    if (bus.start) begin
      state_d    = ST_BASE;
      b_d        = STEP_W'(1);
      mismatch_d = 1'b0;
      done_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_BASE: begin
          if (bus.in_valid) begin
            prev_d  = bus.in_w;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (bus.in_valid) begin
            op_valid_d = 1'b1;
            op_step_d  = b_q;
            prev_d     = bus.in_w;
            b_d        = b_q + STEP_W'(1);
            if (match == 4'd0) begin
              // Nothing explains this sample: report op 0 and stop decoding.
              op_d       = OP_ADD;
              ambig_d    = 1'b0;
              mismatch_d = 1'b1;
              state_d    = ST_ERROR;
            end else begin
              op_d    = op_prio(match);
              ambig_d = multi_hot(match);
              if (b_q == STEP_W'(MAX_STEPS)) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
              end
            end
          end
        end
        default: ;  // IDLE, DONE, ERROR ignore samples
      endcase
    end
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_q     <= '0;
      b_q        <= '0;
      op_valid_q <= 1'b0;
      op_q       <= OP_ADD;
      op_step_q  <= '0;
      ambig_q    <= 1'b0;
      mismatch_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      b_q        <= b_d;
      op_valid_q <= op_valid_d;
      op_q       <= op_d;
      op_step_q  <= op_step_d;
      ambig_q    <= ambig_d;
      mismatch_q <= mismatch_d;
      done_q     <= done_d;
    end
  end

  assign bus.op_valid = op_valid_q;
  assign bus.op       = op_q;
  assign bus.op_step  = op_step_q;
  assign bus.ambig    = ambig_q;
  assign bus.mismatch = mismatch_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q == ST_BASE) || (state_q == ST_DECODE);

endmodule

// File: tb/tb_alu_seq_decoder.sv
// Scoreboard bench: stimulus pushes hand-computed expected reports, a
// negedge monitor pops and compares each op_valid pulse.
module tb_alu_seq_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] step;
    logic       ambig;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  alu_seq_decoder_if dif();

  alu_seq_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (dif.op_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_op_valid: got pulse expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("op",          32'(dif.op),      32'(e.op));
        chk("op_step",     32'(dif.op_step), 32'(e.step));
        chk("ambig",       32'(dif.ambig),   32'(e.ambig));
        chk("pulse_cycle", 32'(cyc),         32'(e.cyc));
      end
    end
  end

  // One cycle of stimulus, applied at the negedge.
  task automatic drive(input logic st, input logic v, input logic [5:0] w);
    @(negedge clk);
    dif.start    = st;
    dif.in_valid = v;
    dif.in_w     = w;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 6'd0);
  endtask

  // Sample expected to produce a report in the following cycle.
  task automatic smp_exp(input logic [5:0] w, input logic [1:0] op,
                         input logic [3:0] step, input logic amb);
    exp_t e;
    drive(1'b0, 1'b1, w);
    e.op = op; e.step = step; e.ambig = amb; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic smp(input logic [5:0] w);
    drive(1'b0, 1'b1, w);
  endtask

  task automatic start_run();
    drive(1'b1, 1'b0, 6'd0);
  endtask

  logic [5:0] stream [9] = '{6'd0, 6'd1, 6'd3, 6'd0, 6'd4, 6'd20, 6'd14, 6'd2, 6'd10};
  logic [1:0] ops    [8] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0};

  initial begin
    dif.start = 1'b0; dif.in_valid = 1'b0; dif.in_w = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_op_valid", 32'(dif.op_valid), 0);
    chk("rst_op",       32'(dif.op),       0);
    chk("rst_op_step",  32'(dif.op_step),  0);
    chk("rst_ambig",    32'(dif.ambig),    0);
    chk("rst_mismatch", 32'(dif.mismatch), 0);
    chk("rst_done",     32'(dif.done),     0);
    chk("rst_busy",     32'(dif.busy),     0);

    // Back-to-back stream.
    start_run();
    idle(1);
    chk("s1_busy", 32'(dif.busy), 1);
    smp(stream[0]);
    for (int k = 1; k < 9; k++) smp_exp(stream[k], ops[k-1], 4'(k), 1'b0);
    idle(1);
    chk("s1_done_with_last", 32'(dif.done), 1);
    idle(2);
    chk("s1_done",     32'(dif.done),     1);
    chk("s1_mismatch", 32'(dif.mismatch), 0);
    chk("s1_busy_end", 32'(dif.busy),     0);
    chk("s1_hold_step", 32'(dif.op_step), 8);
    chk("s1_sb_empty", 32'(sb.size()),    0);

    // Same stream with 3-cycle gaps.
    start_run();
    smp(stream[0]);
    idle(3);
    for (int k = 1; k < 9; k++) begin
      chk("s2_busy", 32'(dif.busy), 1);
      smp_exp(stream[k], ops[k-1], 4'(k), 1'b0);
      idle(3);
    end
    chk("s2_done",     32'(dif.done),     1);
    chk("s2_mismatch", 32'(dif.mismatch), 0);
    chk("s2_sb_empty", 32'(sb.size()),    0);

    // Ambiguous: mul and div both explain 0 -> 0 at b=1.
    start_run();
    idle(1);
    chk("s3_done_cleared", 32'(dif.done), 0);
    smp(6'd0);
    smp_exp(6'd0, 2'd2, 4'd1, 1'b1);
    idle(2);

    // No match: error state, later samples ignored.
    start_run();
    smp(6'd0);
    smp_exp(6'd5, 2'd0, 4'd1, 1'b0);
    idle(2);
    chk("s4_mismatch", 32'(dif.mismatch), 1);
    chk("s4_busy",     32'(dif.busy),     0);
    chk("s4_done",     32'(dif.done),     0);
    smp(6'd6);
    smp(6'd7);
    idle(3);
    chk("s4_mismatch_sticky", 32'(dif.mismatch), 1);
    chk("s4_sb_empty", 32'(sb.size()), 0);

    // Wrap-around cases.
    start_run();
    idle(1);
    chk("s5_mismatch_cleared", 32'(dif.mismatch), 0);
    smp(6'd63);
    smp_exp(6'd0, 2'd0, 4'd1, 1'b0);
    start_run();
    smp(6'd0);
    smp_exp(6'd63, 2'd1, 4'd1, 1'b0);
    start_run();
    smp(6'd39);
    smp_exp(6'd40, 2'd0, 4'd1, 1'b0);
    smp_exp(6'd16, 2'd2, 4'd2, 1'b0);
    idle(2);

    // Restart after the 4th sample.
    start_run();
    smp(stream[0]);
    for (int k = 1; k < 5; k++) smp_exp(stream[k], ops[k-1], 4'(k), 1'b0);
    start_run();
    idle(1);
    chk("s6_busy",      32'(dif.busy),    1);
    chk("s6_hold_step", 32'(dif.op_step), 4);
    smp(6'd63);
    smp_exp(6'd0, 2'd0, 4'd1, 1'b0);
    idle(2);

    // Reset mid-run.
    start_run();
    smp(6'd0);
    smp_exp(6'd1, 2'd0, 4'd1, 1'b0);
    smp_exp(6'd3, 2'd0, 4'd2, 1'b0);
    @(negedge clk);
    dif.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("s7_op_valid", 32'(dif.op_valid), 0);
    chk("s7_op_step",  32'(dif.op_step),  0);
    chk("s7_busy",     32'(dif.busy),     0);
    chk("s7_done",     32'(dif.done),     0);
    smp(6'd5);
    smp(6'd6);
    idle(3);
    chk("s7_idle_ignores", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_decoder.md
Name: alu_seq_decoder

Overview:
- Observer/decoder for the ALU sequencer's W register stream: receives successive W values and recovers the op code (0 add, 1 sub, 2 mul, 3 div) applied at each step.
- Mirrors the producer's B counter internally: step k uses operand b=k.
- Sits beside the controller/ALU pair as a protocol checker.
- Reports decoded op, step index, ambiguity and mismatch.

Parameters:
- W_WIDTH, 6, width of W values and of all arithmetic.
- MAX_STEPS, 8, number of op steps decoded after the baseline sample.
- STEP_W, 4, width of step counter and b mirror; must hold MAX_STEPS.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse; begins a new decode run.
- in_valid  input  1  in_w carries a new W sample this cycle.
- in_w  input  W_WIDTH  sampled W value.
- op_valid  output  1  one-cycle pulse; op/op_step/ambig are valid.
- op  output  2  decoded op code.
- op_step  output  STEP_W  b value (1..MAX_STEPS) of the decoded step.
- ambig  output  1  more than one op matched; valid with op_valid.
- mismatch  output  1  sticky; no op matched at some step.
- done  output  1  level; all MAX_STEPS decoded with no mismatch.
- busy  output  1  high in BASE or DECODE.

Behaviour:
- Reset: state IDLE; op_valid=0, op=0, op_step=0, ambig=0, mismatch=0, done=0, busy=0; internal prev=0, b=0.
- States: IDLE, BASE, DECODE, DONE, ERROR.
- start has priority in every state, including mid-run. It goes to BASE, clears mismatch/done, and sets b=1.
- Reset mid-run returns to IDLE, discarding all progress.
- BASE: in_valid captures prev<=in_w (baseline, no output), then go to DECODE. in_valid in IDLE/DONE/ERROR is ignored.
- DECODE, on in_valid, evaluate all four matches combinationally, all modulo 2^W_WIDTH:
  - add: prev+b==in_w
  - sub: prev-b==in_w (wraps)
  - mul: low W_WIDTH bits of prev*b==in_w
  - div: b!=0 and floor(prev/b)==in_w
- Priority when several match: add > sub > mul > div. ambig=1 if more than one matched.
- Outputs are registered, latency 1: op_valid pulses the cycle after the accepted sample, with op, op_step=b and ambig.
- Each accepted sample also updates prev<=in_w and b<=b+1.
- No match:
  - op_valid still pulses with op=0, ambig=0.
  - mismatch is set, sticky until start/reset.
  - State goes to ERROR; later samples are ignored.
- After the sample with b==MAX_STEPS matches, go to DONE; done rises the same cycle as the last op_valid and holds.
- Back-to-back in_valid every cycle is supported; gaps are allowed with no timeout.
- op/op_step/ambig hold their last values between pulses.

Decomposition:
- Package alu_seq_pkg holds:
  - typedef enum for states
  - typedef enum logic[1:0] op_t {OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3}, shared with the controller
  - constant W_WIDTH
- One combinational sub-module, alu_op_matcher (prev, b, cur -> 4-bit match vector), is natural. It is reusable by the bench's scoreboard.

Test Plan:
- reset; start; feed in_w 0,1,3,0,4,20,14,2,10 one per cycle -> op_valid x8 with op 0,0,1,0,2,1,3,0 and op_step 1..8; ambig=0 throughout; done=1 after the 8th pulse; mismatch=0.
- Same stream with 3-cycle gaps between samples -> identical op sequence, each pulse one cycle after its sample; busy=1 until done.
- Baseline 0, then 0 (b=1) -> mul and div both match; op=2, ambig=1.
- Baseline 0, then 5 -> op_valid with op=0, mismatch=1, state ERROR; further samples produce no op_valid; done stays 0.
- Baseline 63, then 0 (b=1) -> add wraps, op=0. Baseline 0, then 63 -> sub wraps, op=1. Baseline 40, then 16 (b=2, 80 mod 64) -> op=2.
- start after the 4th sample of a run -> returns to BASE, b=1; the next sample is the baseline. reset mid-run -> all outputs 0, IDLE.
